// File: rtl/atpg_comp_pkg.sv
// Shared widths, FSM states and the output record layout
// for the ATPG compression scheduler.
package atpg_comp_pkg;

  localparam int PAT_W  = 9;
  localparam int CODE_W = 4;
  localparam int RUN_W  = 4;

  localparam logic [RUN_W-1:0] RUN_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    FLUSH
  } state_e;

  typedef struct packed {
    logic [1:0]        src;
    logic [CODE_W-1:0] code;
    logic [RUN_W-1:0]  run;
    logic              last;
  } rec_t;

  // Round-robin distance of source k behind the last grant.
  function automatic int rr_dist(
    input int k,
    input int last,
    input int n
  );
    return (k + n - last - 1) % n;
  endfunction

endpackage

// File: rtl/atpg_rr_arbiter.sv
// Round-robin arbiter: grant starts one past the last winner,
// which only moves when the caller pulses advance.
module atpg_rr_arbiter
  import atpg_comp_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] req,
  input  logic               advance,
  output logic [NUM_SRC-1:0] gnt,
  output logic [1:0]         gnt_idx
);

  logic [1:0] last_q;
  logic       found;
  int         best;

  always_comb begin
    best    = NUM_SRC;
    gnt_idx = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (req[k] &&
          rr_dist(k, int'(last_q), NUM_SRC) < best) begin
        best    = rr_dist(k, int'(last_q), NUM_SRC);
        gnt_idx = 2'(k);
      end
    end
  end

  assign found = (best < NUM_SRC);

  always_comb begin
    gnt = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      gnt[k] = found && (gnt_idx == 2'(k));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 2'(NUM_SRC - 1);
    end else if (advance) begin
      last_q <= gnt_idx;
    end
  end

endmodule

// File: rtl/atpg_compression_scheduler.sv
// Burst scheduler with run-length coding of dictionary codes.
// Define SCHED_STATS_EN to add beat/record statistics outputs.
module atpg_compression_scheduler
  import atpg_comp_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*PAT_W-1:0] src_pattern,
  input  logic [NUM_SRC-1:0]       src_last,
  output logic [NUM_SRC-1:0]       src_ready,
  output logic [PAT_W-1:0]         pipe_pattern,
  input  logic [CODE_W-1:0]        pipe_code,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [1:0]               rec_src,
  output logic [CODE_W-1:0]        rec_code,
  output logic [RUN_W-1:0]         rec_run,
  output logic                     rec_last
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]              stat_patterns,
  output logic [15:0]              stat_records
`endif
);

  state_e              state_q, state_d;
  logic [NUM_SRC-1:0]  g_oh_q;
  logic [1:0]          g_idx_q;
  logic [NUM_SRC-1:0]  arb_gnt;
  logic [1:0]          arb_idx;
  logic                grant_take;
  logic [CODE_W-1:0]   cur_code_q, code_d;
  logic [RUN_W-1:0]    run_q, run_d;
  rec_t                slot_q, emit_rec;
  logic                slot_v_q, slot_free;
  logic                emit, accept;
  logic                valid_g, last_g;
  logic [PAT_W-1:0]    pat_g;

  atpg_rr_arbiter #(.NUM_SRC(NUM_SRC)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (src_valid),
    .advance (grant_take),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign valid_g   = |(src_valid & g_oh_q);
  assign last_g    = |(src_last & g_oh_q);
  assign slot_free = !slot_v_q || rec_ready;

  always_comb begin
    pat_g = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (g_oh_q[k]) begin
        pat_g = pat_g | src_pattern[k*PAT_W +: PAT_W];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_take   = 1'b0;
    src_ready    = '0;
    pipe_pattern = '0;
    accept       = 1'b0;
    emit         = 1'b0;
    emit_rec     = '0;
    code_d       = cur_code_q;
    run_d        = run_q;
    unique case (state_q)
      IDLE: begin
        if (|src_valid) begin
          grant_take = 1'b1;
          state_d    = STREAM;
        end
      end
      STREAM: begin
        src_ready    = g_oh_q & {NUM_SRC{slot_free}};
        pipe_pattern = pat_g;
        accept       = valid_g && slot_free;
        if (accept) begin
          if (run_q == '0) begin
            code_d = pipe_code;
            run_d  = RUN_W'(1);
          end else if (pipe_code == cur_code_q &&
                       run_q != RUN_MAX) begin
            run_d = run_q + 1'b1;
          end else begin
            emit          = 1'b1;
            emit_rec.src  = g_idx_q;
            emit_rec.code = cur_code_q;
            emit_rec.run  = run_q;
            emit_rec.last = 1'b0;
            code_d        = pipe_code;
            run_d         = RUN_W'(1);
          end
          if (last_g) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (slot_free) begin
          emit          = 1'b1;
          emit_rec.src  = g_idx_q;
          emit_rec.code = cur_code_q;
          emit_rec.run  = run_q;
          emit_rec.last = 1'b1;
          run_d         = '0;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      g_oh_q     <= '0;
      g_idx_q    <= '0;
      cur_code_q <= '0;
      run_q      <= '0;
      slot_v_q   <= 1'b0;
      slot_q     <= '0;
    end else begin
      state_q    <= state_d;
      cur_code_q <= code_d;
      run_q      <= run_d;
      if (grant_take) begin
        g_oh_q  <= arb_gnt;
        g_idx_q <= arb_idx;
      end
      // A new record may only land when the slot is empty or draining.
      if (emit) begin
        slot_v_q <= 1'b1;
        slot_q   <= emit_rec;
      end else if (rec_ready) begin
        slot_v_q <= 1'b0;
      end
    end
  end

  assign rec_valid = slot_v_q;
  assign rec_src   = slot_q.src;
  assign rec_code  = slot_q.code;
  assign rec_run   = slot_q.run;
  assign rec_last  = slot_q.last;

`ifdef SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_patterns <= '0;
      stat_records  <= '0;
    end else begin
      if (accept && stat_patterns != 16'hFFFF) begin
        stat_patterns <= stat_patterns + 16'd1;
      end
      if (slot_v_q && rec_ready &&
          stat_records != 16'hFFFF) begin
        stat_records <= stat_records + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_atpg_compression_scheduler.sv
// Directed bench: per-cycle vector table plus burst sequences
// checked against hand-computed record lists.
module tb_atpg_compression_scheduler;
  import atpg_comp_pkg::*;

  localparam int N = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [N-1:0]       src_valid, src_last, src_ready;
  logic [N*PAT_W-1:0] src_pattern;
  logic [PAT_W-1:0]   pipe_pattern;
  logic [CODE_W-1:0]  pipe_code;
  logic               rec_valid, rec_ready, rec_last;
  logic [1:0]         rec_src;
  logic [CODE_W-1:0]  rec_code;
  logic [RUN_W-1:0]   rec_run;
`ifdef SCHED_STATS_EN
  logic [15:0]        stat_patterns, stat_records;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Dictionary stub: code is the low nibble of the pattern.
  assign pipe_code = pipe_pattern[CODE_W-1:0];

  atpg_compression_scheduler #(.NUM_SRC(N)) dut (
    .clk          (clk),
    .reset        (reset),
    .src_valid    (src_valid),
    .src_pattern  (src_pattern),
    .src_last     (src_last),
    .src_ready    (src_ready),
    .pipe_pattern (pipe_pattern),
    .pipe_code    (pipe_code),
    .rec_valid    (rec_valid),
    .rec_ready    (rec_ready),
    .rec_src      (rec_src),
    .rec_code     (rec_code),
    .rec_run      (rec_run),
    .rec_last     (rec_last)
`ifdef SCHED_STATS_EN
    ,
    .stat_patterns(stat_patterns),
    .stat_records (stat_records)
`endif
  );

  typedef struct {
    logic [1:0]       v;
    logic [PAT_W-1:0] p0;
    logic [1:0]       l;
    logic             rr;
    logic [1:0]       sr;
    logic [PAT_W-1:0] pp;
    logic             rv;
    rec_t             rec;
  } vec_t;

  vec_t tbl[17];
  rec_t got_q[$];
  rec_t exp_q[$];

  always @(negedge clk) begin
    if (!reset && rec_valid && rec_ready) begin
      got_q.push_back({rec_src, rec_code, rec_run, rec_last});
    end
  end

  function automatic vec_t mk(
    input logic [1:0] v, input logic [8:0] p0,
    input logic [1:0] l, input logic rr,
    input logic [1:0] sr, input logic [8:0] pp,
    input logic rv, input rec_t rec
  );
    vec_t t;
    t.v = v; t.p0 = p0; t.l = l; t.rr = rr;
    t.sr = sr; t.pp = pp; t.rv = rv; t.rec = rec;
    return t;
  endfunction

  function automatic rec_t r(
    input int s, input int c, input int n, input int l
  );
    rec_t x;
    x.src = 2'(s); x.code = 4'(c);
    x.run = 4'(n); x.last = 1'(l);
    return x;
  endfunction

  task automatic chk(
    input string name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_recs(input string name);
    chk({name, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s rec%0d", name, i),
          32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    src_valid = '0;
    src_last  = '0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send_burst(
    input int s, input int n, input logic [127:0] codes
  );
    for (int k = 0; k < n; k++) begin
      int waited;
      waited = 0;
      src_pattern[s*PAT_W +: PAT_W] = {5'(k), codes[k*4 +: 4]};
      src_last[s]  = (k == n - 1);
      src_valid[s] = 1'b1;
      @(negedge clk);
      while (!src_ready[s] && waited < 60) begin
        waited++;
        @(negedge clk);
      end
      if (!src_ready[s]) begin
        n_cmp++;
        n_bad++;
        $display("FAIL burst src%0d beat %0d: ready low, want high",
                 s, k);
      end
      @(posedge clk);
      #1;
    end
    src_valid[s] = 1'b0;
    src_last[s]  = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time expired");
    $fatal(1);
  end

  initial begin
    src_pattern = '0;
    rec_ready   = 1'b1;
    do_reset();

    @(negedge clk);
    chk("rst src_ready", 32'(src_ready), 0);
    chk("rst rec_valid", 32'(rec_valid), 0);
    chk("rst rec_src",   32'(rec_src),   0);
    chk("rst rec_code",  32'(rec_code),  0);
    chk("rst rec_run",   32'(rec_run),   0);
    chk("rst rec_last",  32'(rec_last),  0);
    chk("rst pipe",      32'(pipe_pattern), 0);
    @(posedge clk);
    #1;

    // Codes 3,3,3,7 then a backpressured 1,2,3 burst.
    tbl[0]  = mk(2'b01, 9'h013, 0, 1, 2'b00, 9'h000, 0, r(0,0,0,0));
    tbl[1]  = mk(2'b01, 9'h013, 0, 1, 2'b01, 9'h013, 0, r(0,0,0,0));
    tbl[2]  = mk(2'b01, 9'h023, 0, 1, 2'b01, 9'h023, 0, r(0,0,0,0));
    tbl[3]  = mk(2'b01, 9'h033, 0, 1, 2'b01, 9'h033, 0, r(0,0,0,0));
    tbl[4]  = mk(2'b01, 9'h047, 1, 1, 2'b01, 9'h047, 0, r(0,0,0,0));
    tbl[5]  = mk(2'b00, 9'h000, 0, 1, 2'b00, 9'h000, 1, r(0,3,3,0));
    tbl[6]  = mk(2'b00, 9'h000, 0, 1, 2'b00, 9'h000, 1, r(0,7,1,1));
    tbl[7]  = mk(2'b00, 9'h000, 0, 1, 2'b00, 9'h000, 0, r(0,0,0,0));
    tbl[8]  = mk(2'b01, 9'h051, 0, 0, 2'b00, 9'h000, 0, r(0,0,0,0));
    tbl[9]  = mk(2'b01, 9'h051, 0, 0, 2'b01, 9'h051, 0, r(0,0,0,0));
    tbl[10] = mk(2'b01, 9'h062, 0, 0, 2'b01, 9'h062, 0, r(0,0,0,0));
    tbl[11] = mk(2'b01, 9'h073, 1, 0, 2'b00, 9'h073, 1, r(0,1,1,0));
    tbl[12] = mk(2'b01, 9'h073, 1, 0, 2'b00, 9'h073, 1, r(0,1,1,0));
    tbl[13] = mk(2'b01, 9'h073, 1, 1, 2'b01, 9'h073, 1, r(0,1,1,0));
    tbl[14] = mk(2'b00, 9'h000, 0, 1, 2'b00, 9'h000, 1, r(0,2,1,0));
    tbl[15] = mk(2'b00, 9'h000, 0, 1, 2'b00, 9'h000, 1, r(0,3,1,1));
    tbl[16] = mk(2'b00, 9'h000, 0, 1, 2'b00, 9'h000, 0, r(0,0,0,0));

    for (int i = 0; i < 17; i++) begin
      src_valid   = tbl[i].v;
      src_pattern = {9'h000, tbl[i].p0};
      src_last    = tbl[i].l;
      rec_ready   = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("t%0d src_ready", i), 32'(src_ready), 32'(tbl[i].sr));
      chk($sformatf("t%0d pipe", i), 32'(pipe_pattern), 32'(tbl[i].pp));
      chk($sformatf("t%0d rec_valid", i), 32'(rec_valid), 32'(tbl[i].rv));
      if (tbl[i].rv) begin
        chk($sformatf("t%0d rec", i),
            32'({rec_src, rec_code, rec_run, rec_last}),
            32'(tbl[i].rec));
      end
      @(posedge clk);
      #1;
    end
    got_q.delete();

    // Saturation: 20 identical codes from source 1.
    rec_ready = 1'b1;
    send_burst(1, 20, {32{4'h5}});
    drain();
    exp_q.push_back(r(1,5,15,0));
    exp_q.push_back(r(1,5,5,1));
    check_recs("sat");

    // Contention from reset, then contention again.
    do_reset();
    fork
      send_burst(0, 2, 128'h22);
      send_burst(1, 1, 128'h9);
    join
    drain();
    fork
      send_burst(0, 1, 128'h4);
      send_burst(1, 2, 128'h86);
    join
    drain();
    exp_q.push_back(r(0,2,2,1));
    exp_q.push_back(r(1,9,1,1));
    exp_q.push_back(r(0,4,1,1));
    exp_q.push_back(r(1,6,1,0));
    exp_q.push_back(r(1,8,1,1));
    check_recs("rr");

    // Reset three beats into a burst.
    src_pattern[8:0] = 9'h011;
    src_last  = '0;
    src_valid = 2'b01;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 src_pattern[8:0] = 9'h022;
    @(posedge clk);
    #1 src_pattern[8:0] = 9'h033;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid rec_valid", 32'(rec_valid), 1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post-rst rec_valid", 32'(rec_valid), 0);
    chk("post-rst src_ready", 32'(src_ready), 0);
    got_q.delete();
    @(posedge clk);
    #1 src_last = 2'b01;
    @(posedge clk);
    #1 src_valid = '0;
    src_last = '0;
    drain();
    exp_q.push_back(r(0,3,1,1));
    check_recs("clean");

`ifdef SCHED_STATS_EN
    do_reset();
    send_burst(0, 4, 128'h2211);
    drain();
    send_burst(0, 3, 128'h633);
    drain();
    chk("stat_patterns", 32'(stat_patterns), 7);
    chk("stat_records",  32'(stat_records),  4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
